// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: access-type encodings, the
// ownership state type, and a counter-width helper.
package ram_arbiter_pkg;

    // Bus access type as seen on cpu_RW / host_RW / ram_RW
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Who currently drives the RAM bus
    typedef enum logic {
        ST_CPU_OWN  = 1'b0,
        ST_HOST_OWN = 1'b1
    } arb_state_t;

    // Bits needed to count 0..n-1, never less than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Shares a single-port, registered-read RAM between the 6502 core and a
// pipelined host/DMA port. The host gets bursts of up to HOST_BURST
// accesses, after which the core is guaranteed at least CPU_MIN cycles.
// Read data for both sides is held in registers so it stays stable while
// the other side owns the bus.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 8,
    parameter int HOST_BURST = 4,
    parameter int CPU_MIN    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    // core side
    input  logic          cpu_RW,
    input  logic [AW-1:0] cpu_AD,
    input  logic [DW-1:0] cpu_D_out,
    output logic [DW-1:0] cpu_D_in,
    output logic          cpu_rdy,
    // host side
    input  logic          host_req,
    input  logic          host_RW,
    input  logic [AW-1:0] host_AD,
    input  logic [DW-1:0] host_D_wr,
    output logic          host_ack,
    output logic          host_rvalid,
    output logic [DW-1:0] host_D_rd,
    // RAM side
    output logic          ram_RW,
    output logic [AW-1:0] ram_AD,
    output logic [DW-1:0] ram_D_in,
    input  logic [DW-1:0] ram_D_out
);

    localparam int BW = cnt_width(HOST_BURST);
    localparam int HW = cnt_width(CPU_MIN);
    localparam logic [BW-1:0] BURST_LAST = BW'(HOST_BURST - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(CPU_MIN - 1);

    arb_state_t    state_reg, state_next;
    logic [BW-1:0] burst_cnt_reg, burst_cnt_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;

    logic          cpu_done_reg;    // core access was performed last cycle
    logic [DW-1:0] cpu_hold_reg;
    logic          host_rvalid_reg;
    logic [DW-1:0] host_hold_reg;

    logic          host_sel;

    // Ownership FSM: next state, counters and the combinational handshakes.
    // While rst_n is low everything is forced to the idle/no-write values.
    always_comb begin
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        hold_cnt_next  = hold_cnt_reg;
        host_sel       = 1'b0;
        cpu_rdy        = 1'b0;
        host_ack       = 1'b0;
        ram_RW         = RW_READ;
        if (rst_n) begin
            case (state_reg)
                ST_CPU_OWN: begin
                    cpu_rdy = 1'b1;
                    ram_RW  = cpu_RW;
                    if (hold_cnt_reg != '0) begin
                        hold_cnt_next = hold_cnt_reg - HW'(1);
                    end
                    // The request cycle itself still belongs to the core
                    if (host_req && (hold_cnt_reg == '0)) begin
                        state_next = ST_HOST_OWN;
                    end
                end
                ST_HOST_OWN: begin
                    host_sel = 1'b1;
                    if (host_req) begin
                        host_ack = 1'b1;
                        ram_RW   = host_RW;
                        if (burst_cnt_reg < BURST_LAST) begin
                            burst_cnt_next = burst_cnt_reg + BW'(1);
                        end else begin
                            // Burst exhausted: hand back and guard the core
                            state_next     = ST_CPU_OWN;
                            burst_cnt_next = '0;
                            hold_cnt_next  = HOLD_LOAD;
                        end
                    end else begin
                        // Host went idle: no write, give the bus back
                        state_next     = ST_CPU_OWN;
                        burst_cnt_next = '0;
                    end
                end
                default: begin
                    state_next     = ST_CPU_OWN;
                    burst_cnt_next = '0;
                end
            endcase
        end
    end

    // RAM address/data mux follows the current owner
    always_comb begin
        ram_AD   = host_sel ? host_AD   : cpu_AD;
        ram_D_in = host_sel ? host_D_wr : cpu_D_out;
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_CPU_OWN;
            burst_cnt_reg <= '0;
            hold_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
            hold_cnt_reg  <= hold_cnt_next;
        end
    end

    // Read-data tracking: remember which side's data arrives next cycle
    // and capture it so it survives stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_done_reg    <= 1'b0;
            cpu_hold_reg    <= '0;
            host_rvalid_reg <= 1'b0;
            host_hold_reg   <= '0;
        end else begin
            cpu_done_reg    <= cpu_rdy;
            host_rvalid_reg <= host_ack && (host_RW == RW_READ);
            if (cpu_done_reg) begin
                cpu_hold_reg <= ram_D_out;
            end
            if (host_rvalid_reg) begin
                host_hold_reg <= ram_D_out;
            end
        end
    end

    // Fresh RAM data in the cycle it arrives, held copy otherwise
    always_comb begin
        cpu_D_in    = cpu_done_reg    ? ram_D_out : cpu_hold_reg;
        host_D_rd   = host_rvalid_reg ? ram_D_out : host_hold_reg;
        host_rvalid = host_rvalid_reg;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with HOST_BURST=4, CPU_MIN=1 and a
// behavioural registered-read RAM. Inputs change 1ns after posedge,
// outputs are sampled 4ns after posedge.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_RW;
    logic [AW-1:0] cpu_AD;
    logic [DW-1:0] cpu_D_out;
    logic [DW-1:0] cpu_D_in;
    logic          cpu_rdy;
    logic          host_req;
    logic          host_RW;
    logic [AW-1:0] host_AD;
    logic [DW-1:0] host_D_wr;
    logic          host_ack;
    logic          host_rvalid;
    logic [DW-1:0] host_D_rd;
    logic          ram_RW;
    logic [AW-1:0] ram_AD;
    logic [DW-1:0] ram_D_in;
    logic [DW-1:0] ram_D_out;

    int n_checks = 0;
    int n_fail   = 0;

    // RAM model: preloaded contents, write on ram_RW=0, registered read
    logic [7:0] mem [0:65535] = '{0: 8'hEA, 1: 8'hA9, 2: 8'h55, 3: 8'h69,
                                  4: 8'h03, 5: 8'h29, 16'h0300: 8'h42,
                                  default: 8'h00};
    logic [7:0] ram_q = 8'h00;
    assign ram_D_out = ram_q;

    always @(posedge clk) begin
        if (ram_RW == RW_WRITE) mem[ram_AD] <= ram_D_in;
        ram_q <= mem[ram_AD];
    end

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW), .HOST_BURST(4), .CPU_MIN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_RW(cpu_RW), .cpu_AD(cpu_AD), .cpu_D_out(cpu_D_out),
        .cpu_D_in(cpu_D_in), .cpu_rdy(cpu_rdy),
        .host_req(host_req), .host_RW(host_RW), .host_AD(host_AD),
        .host_D_wr(host_D_wr), .host_ack(host_ack), .host_rvalid(host_rvalid),
        .host_D_rd(host_D_rd),
        .ram_RW(ram_RW), .ram_AD(ram_AD), .ram_D_in(ram_D_in), .ram_D_out(ram_D_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        tick(); settle();
        n_checks++; if (cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_rdy: got %b want 0", cpu_rdy); end
        n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL rst_host_ack: got %b want 0", host_ack); end
        n_checks++; if (ram_RW !== 1'b1) begin n_fail++; $display("FAIL rst_ram_RW: got %b want 1", ram_RW); end
        n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", host_rvalid); end
        n_checks++; if (cpu_D_in !== 8'h00) begin n_fail++; $display("FAIL rst_cpu_D_in: got %h want 00", cpu_D_in); end
        n_checks++; if (host_D_rd !== 8'h00) begin n_fail++; $display("FAIL rst_host_D_rd: got %h want 00", host_D_rd); end
        // release; the core reads 0001 in the first cycle after release
        tick(); rst_n = 1'b1; cpu_AD = 16'h0001; settle();
        n_checks++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL rel_cpu_rdy0: got %b want 1", cpu_rdy); end
        tick(); cpu_AD = 16'h0002; settle();
        n_checks++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL rel_cpu_rdy1: got %b want 1", cpu_rdy); end
        n_checks++; if (cpu_D_in !== 8'hA9) begin n_fail++; $display("FAIL rel_cpu_D_in: got %h want a9", cpu_D_in); end
        tick(); settle();
        n_checks++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL rel_cpu_rdy2: got %b want 1", cpu_rdy); end
        n_checks++; if (cpu_D_in !== 8'h55) begin n_fail++; $display("FAIL rel_cpu_D_in2: got %h want 55", cpu_D_in); end
        $display("reset: released, core read 0001 -> %h", 8'hA9);
    endtask

    task automatic test_host_write();
        // t: request raised while the core reads 0200
        tick(); cpu_AD = 16'h0200; host_req = 1'b1; host_RW = RW_WRITE;
        host_AD = 16'h0200; host_D_wr = 8'h5A; settle();
        n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL hw_t_ack: got %b want 0", host_ack); end
        n_checks++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL hw_t_rdy: got %b want 1", cpu_rdy); end
        // t+1: host owns the bus and its write is presented
        tick(); settle();
        n_checks++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL hw_t1_ack: got %b want 1", host_ack); end
        n_checks++; if (cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL hw_t1_rdy: got %b want 0", cpu_rdy); end
        n_checks++; if ({ram_RW, ram_AD, ram_D_in} !== {1'b0, 16'h0200, 8'h5A}) begin n_fail++;
            $display("FAIL hw_t1_bus: got %b/%h/%h want 0/0200/5a", ram_RW, ram_AD, ram_D_in); end
        n_checks++; if (cpu_D_in !== 8'h00) begin n_fail++; $display("FAIL hw_t1_cpu_D_in: got %h want 00", cpu_D_in); end
        // t+2: host idle in HOST_OWN, bus released next cycle
        tick(); host_req = 1'b0; settle();
        n_checks++; if (mem[16'h0200] !== 8'h5A) begin n_fail++; $display("FAIL hw_ram: got %h want 5a", mem[16'h0200]); end
        n_checks++; if (host_ack !== 1'b0 || ram_RW !== 1'b1) begin n_fail++;
            $display("FAIL hw_t2_idle: got ack=%b rw=%b want 0/1", host_ack, ram_RW); end
        // t+3: core re-presents 0200 and is served
        tick(); settle();
        n_checks++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL hw_t3_rdy: got %b want 1", cpu_rdy); end
        tick(); settle();
        n_checks++; if (cpu_D_in !== 8'h5A) begin n_fail++; $display("FAIL hw_t4_cpu_D_in: got %h want 5a", cpu_D_in); end
        $display("host write 0200 <= 5a, core reread -> %h", cpu_D_in);
    endtask

    task automatic test_back_to_back();
        logic       exp_ack [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       exp_rdy [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       exp_rv  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] exp_d   [10] = '{8'h00, 8'h00, 8'hEA, 8'hA9, 8'h55, 8'h69, 8'h69, 8'h03, 8'h29, 8'h29};
        int next_addr = 0;
        cpu_AD = 16'h0010;
        host_RW = RW_READ;
        for (int i = 0; i < 10; i++) begin
            tick();
            host_req = (next_addr < 6);
            host_AD  = 16'(next_addr);
            settle();
            n_checks++; if (host_ack !== exp_ack[i]) begin n_fail++; $display("FAIL b2b_ack[%0d]: got %b want %b", i, host_ack, exp_ack[i]); end
            n_checks++; if (cpu_rdy !== exp_rdy[i]) begin n_fail++; $display("FAIL b2b_rdy[%0d]: got %b want %b", i, cpu_rdy, exp_rdy[i]); end
            n_checks++; if (host_rvalid !== exp_rv[i]) begin n_fail++; $display("FAIL b2b_rvalid[%0d]: got %b want %b", i, host_rvalid, exp_rv[i]); end
            n_checks++; if (host_D_rd !== exp_d[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, host_D_rd, exp_d[i]); end
            if (host_rvalid) $display("host read data %h (cycle %0d)", host_D_rd, i);
            if (host_ack) next_addr++;
        end
        host_req = 1'b0;
    endtask

    task automatic test_stall_hold();
        tick(); cpu_AD = 16'h0001; settle();
        // t: core reads 0003 while the host requests three reads
        tick(); cpu_AD = 16'h0003; host_req = 1'b1; host_RW = RW_READ; host_AD = 16'h0000; settle();
        n_checks++; if (cpu_D_in !== 8'hA9) begin n_fail++; $display("FAIL st_t_cpu_D_in: got %h want a9", cpu_D_in); end
        for (int j = 1; j <= 4; j++) begin
            tick();
            host_AD  = 16'(j - 1);
            host_req = (j <= 3);
            settle();
            n_checks++; if (cpu_D_in !== 8'h69) begin n_fail++; $display("FAIL st_cpu_D_in[t+%0d]: got %h want 69", j, cpu_D_in); end
            n_checks++; if (cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL st_rdy[t+%0d]: got %b want 0", j, cpu_rdy); end
        end
        tick(); settle();
        n_checks++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL st_t5_rdy: got %b want 1", cpu_rdy); end
        $display("stall hold: core data %h kept across host burst", cpu_D_in);
    endtask

    task automatic test_req_drop();
        tick(); cpu_AD = 16'h0010; host_req = 1'b1; host_RW = RW_READ; host_AD = 16'h0004; settle();
        n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL rd_t_ack: got %b want 0", host_ack); end
        tick(); settle();
        n_checks++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL rd_t1_ack: got %b want 1", host_ack); end
        // request dropped with a write pattern still on the host lines
        tick(); host_req = 1'b0; host_RW = RW_WRITE; host_AD = 16'h0005; host_D_wr = 8'hFF; settle();
        n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL rd_t2_ack: got %b want 0", host_ack); end
        n_checks++; if (ram_RW !== 1'b1) begin n_fail++; $display("FAIL rd_t2_ram_RW: got %b want 1", ram_RW); end
        n_checks++; if (cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL rd_t2_rdy: got %b want 0", cpu_rdy); end
        tick(); host_req = 1'b1; host_RW = RW_READ; settle();
        n_checks++; if (cpu_rdy !== 1'b1 || host_ack !== 1'b0) begin n_fail++;
            $display("FAIL rd_t3_cpu: got rdy=%b ack=%b want 1/0", cpu_rdy, host_ack); end
        tick(); settle();
        n_checks++; if (host_ack !== 1'b1 || cpu_rdy !== 1'b0) begin n_fail++;
            $display("FAIL rd_t4_regain: got ack=%b rdy=%b want 1/0", host_ack, cpu_rdy); end
        tick(); host_req = 1'b0; settle();
        tick(); settle();
        n_checks++; if (mem[16'h0005] !== 8'h29) begin n_fail++; $display("FAIL rd_ram5: got %h want 29", mem[16'h0005]); end
        $display("req drop: bus regained, ram[0005]=%h", mem[16'h0005]);
    endtask

    task automatic test_reset_mid_burst();
        tick(); host_req = 1'b1; host_RW = RW_READ; host_AD = 16'h0000; settle();
        tick(); settle();
        n_checks++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL rm_t1_ack: got %b want 1", host_ack); end
        // t+2: write 0300<=77 presented and reset asserted together
        tick(); host_RW = RW_WRITE; host_AD = 16'h0300; host_D_wr = 8'h77; rst_n = 1'b0; settle();
        n_checks++; if (ram_RW !== 1'b1) begin n_fail++; $display("FAIL rm_ram_RW: got %b want 1", ram_RW); end
        n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL rm_ack: got %b want 0", host_ack); end
        n_checks++; if (cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL rm_rdy: got %b want 0", cpu_rdy); end
        n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL rm_rvalid: got %b want 0", host_rvalid); end
        n_checks++; if (host_D_rd !== 8'h00 || cpu_D_in !== 8'h00) begin n_fail++;
            $display("FAIL rm_held: got host=%h cpu=%h want 00/00", host_D_rd, cpu_D_in); end
        tick(); settle();
        n_checks++; if (mem[16'h0300] !== 8'h42) begin n_fail++; $display("FAIL rm_ram300: got %h want 42", mem[16'h0300]); end
        tick(); host_req = 1'b0; rst_n = 1'b1; settle();
        n_checks++; if (cpu_rdy !== 1'b1 || host_ack !== 1'b0 || host_rvalid !== 1'b0) begin n_fail++;
            $display("FAIL rm_release: got rdy=%b ack=%b rv=%b want 1/0/0", cpu_rdy, host_ack, host_rvalid); end
        tick(); settle();
        n_checks++; if (cpu_rdy !== 1'b1 || host_rvalid !== 1'b0) begin n_fail++;
            $display("FAIL rm_after: got rdy=%b rv=%b want 1/0", cpu_rdy, host_rvalid); end
        $display("reset mid-burst: ram[0300]=%h after aborted write", mem[16'h0300]);
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_RW    = RW_READ;
        cpu_AD    = 16'h0000;
        cpu_D_out = 8'h00;
        host_req  = 1'b0;
        host_RW   = RW_READ;
        host_AD   = 16'h0000;
        host_D_wr = 8'h00;
        test_reset();
        test_host_write();
        test_back_to_back();
        test_stall_hold();
        test_req_drop();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule
